// File: rtl/vlsu_req_sequencer.sv
// vlsu_req_sequencer: buffers one multi-lane VLSU command, issues it to the dcache and returns the collected lane results
module vlsu_req_sequencer #(
  parameter int NUM_LANES = 8,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int CNT_W = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [NUM_LANES-1:0]            cmd_lane_valid_i,
  input  logic [NUM_LANES-1:0]            cmd_lane_we_i,
  input  logic [NUM_LANES*(DATA_W/8)-1:0] cmd_lane_be_i,
  input  logic [NUM_LANES*ADDR_W-1:0]     cmd_lane_addr_i,
  input  logic [NUM_LANES*DATA_W-1:0]     cmd_lane_wdata_i,
  output logic                            vlsu_req_o,
  output logic [NUM_LANES-1:0]            vlsu_lane_valid_o,
  output logic [NUM_LANES-1:0]            vlsu_lane_we_o,
  output logic [NUM_LANES*(DATA_W/8)-1:0] vlsu_lane_be_o,
  output logic [NUM_LANES*ADDR_W-1:0]     vlsu_lane_addr_o,
  output logic [NUM_LANES*DATA_W-1:0]     vlsu_lane_wdata_o,
  input  logic                            vlsu_ready_i,
  input  logic                            vlsu_done_i,
  input  logic [NUM_LANES-1:0]            vlsu_lane_done_i,
  input  logic [NUM_LANES-1:0]            vlsu_lane_hit_i,
  input  logic [NUM_LANES*DATA_W-1:0]     vlsu_lane_rdata_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [NUM_LANES*DATA_W-1:0]     rsp_lane_rdata_o,
  output logic [NUM_LANES-1:0]            rsp_lane_hit_o,
  output logic [NUM_LANES-1:0]            rsp_lane_done_o,
  output logic                            rsp_timeout_o,
  output logic [CNT_W-1:0]                rsp_cycles_o,
  output logic [2:0]                      state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, RESP = 3'd3} state_t;
  state_t state;
  logic [NUM_LANES-1:0] pending, cap, left;
  logic [CNT_W-1:0] cnt;
  logic complete, expire;
  // vlsu_done_i sweeps every still-pending lane in the same cycle
  assign cap = pending & (vlsu_lane_done_i | {NUM_LANES{vlsu_done_i}});
  assign left = pending & ~cap;
  assign complete = (state == WAIT) && (left == '0 || vlsu_done_i);
  assign expire = !complete && (cnt + CNT_W'(1) == CNT_W'(TIMEOUT_CYCLES));
  assign state_o = state;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cmd_ready_o <= 1'b1;
      vlsu_req_o <= 1'b0;
      vlsu_lane_valid_o <= '0;
      vlsu_lane_we_o <= '0;
      vlsu_lane_be_o <= '0;
      vlsu_lane_addr_o <= '0;
      vlsu_lane_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_lane_rdata_o <= '0;
      rsp_lane_hit_o <= '0;
      rsp_lane_done_o <= '0;
      rsp_timeout_o <= 1'b0;
      rsp_cycles_o <= '0;
      pending <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i) begin
          vlsu_lane_valid_o <= cmd_lane_valid_i;
          vlsu_lane_we_o <= cmd_lane_we_i;
          vlsu_lane_be_o <= cmd_lane_be_i;
          vlsu_lane_addr_o <= cmd_lane_addr_i;
          vlsu_lane_wdata_o <= cmd_lane_wdata_i;
          pending <= cmd_lane_valid_i;
          rsp_lane_rdata_o <= '0;
          rsp_lane_hit_o <= '0;
          rsp_lane_done_o <= '0;
          rsp_timeout_o <= 1'b0;
          rsp_cycles_o <= '0;
          cnt <= '0;
          cmd_ready_o <= 1'b0;
          vlsu_req_o <= |cmd_lane_valid_i;
          rsp_valid_o <= ~|cmd_lane_valid_i;
          state <= |cmd_lane_valid_i ? ISSUE : RESP;
        end
        ISSUE: if (expire) begin
          vlsu_req_o <= 1'b0;
          rsp_timeout_o <= 1'b1;
          rsp_cycles_o <= CNT_W'(TIMEOUT_CYCLES);
          rsp_valid_o <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (vlsu_ready_i) begin
            vlsu_req_o <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          for (int i = 0; i < NUM_LANES; i++) if (cap[i]) begin
            rsp_lane_hit_o[i] <= vlsu_lane_hit_i[i];
            rsp_lane_done_o[i] <= 1'b1;
            if (!vlsu_lane_we_o[i]) rsp_lane_rdata_o[i*DATA_W +: DATA_W] <= vlsu_lane_rdata_i[i*DATA_W +: DATA_W];
          end
          pending <= left;
          if (complete || expire) begin
            rsp_timeout_o <= !complete;
            rsp_cycles_o <= complete ? cnt + CNT_W'(1) : CNT_W'(TIMEOUT_CYCLES);
            rsp_valid_o <= 1'b1;
            state <= RESP;
          end else cnt <= cnt + CNT_W'(1);
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
